// File: rtl/seq_divider_4bit.sv
// seq_divider_4bit: restoring divider that retires one quotient bit per clock.
// A single WIDTH+1-bit subtractor is reused every iteration.
module seq_divider_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH:0]   part_q, part_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   nxt_part;
    logic [WIDTH-1:0] nxt_quo;
    logic             ge;
    logic             accept;

    // One shift/compare/subtract step on the partial remainder.
    always_comb begin
        shifted  = {part_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        ge       = (shifted >= {1'b0, dvs_q});
        nxt_part = ge ? diff : shifted;
        nxt_quo  = {quo_q[WIDTH-2:0], ge};
        accept   = start && (state_q != S_RUN);
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        part_d  = '0;
                        quo_d   = '0;
                        cnt_d   = CW'(WIDTH);
                    end
                end
            end
            S_RUN: begin
                dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                part_d = nxt_part;
                quo_d  = nxt_quo;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    q_d     = nxt_quo;
                    r_d     = nxt_part[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_4bit.sv
// tb_seq_divider_4bit: directed and exhaustive checks of seq_divider_4bit.
// Driver pushes expected results; a negedge monitor pops them on done.
module tb_seq_divider_4bit;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider_4bit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        bit z;
        int c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   npass  = 0;
    int   ntotal = 0;

    task automatic chk(input string name, input int act, input int exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected done cycle: start edge plus WIDTH iterations (none for /0).
    task automatic push(input int a, input int b, input int q,
                        input int r, input bit z);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.z = z;
        e.c = cyc + 1 + (z ? 0 : W);
        sb.push_back(e);
    endtask

    task automatic issue(input int a, input int b, input int q,
                         input int r, input bit z);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        push(a, b, q, r, z);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            ntotal++;
            $display("FAIL done_timeout: got %0d pending, expected 0",
                     sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (busy && done) begin
            ntotal++;
            $display("FAIL busy_done_overlap: got both high, expected exclusive");
        end
        if (!rst && done) begin
            if (sb.size() == 0) begin
                ntotal++;
                $display("FAIL spurious_done: got done=1, expected no pending op");
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", int'(quotient), mon_e.q);
                chk("remainder", int'(remainder), mon_e.r);
                chk("div_by_zero", int'(div_by_zero), int'(mon_e.z));
                chk("done_cycle", cyc, mon_e.c);
                if (!mon_e.z) begin
                    chk("invariant", int'(quotient) * mon_e.b
                        + int'(remainder), mon_e.a);
                    chk("rem_lt_div", int'(int'(remainder) < mon_e.b), 1);
                end
            end
        end
    end

    int hv_a[4] = '{13, 15, 6, 11};
    int hv_b[4] = '{3, 2, 6, 4};
    int hv_q[4] = '{4, 7, 1, 2};
    int hv_r[4] = '{1, 1, 0, 3};

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_q", int'(quotient), 0);
        chk("reset_r", int'(remainder), 0);
        chk("reset_dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(13, 3, 4, 1, 0);
        for (int i = 0; i < W; i++) begin
            chk("busy_run", int'(busy), 1);
            chk("no_early_done", int'(done), 0);
            @(negedge clk);
        end
        chk("busy_at_done", int'(busy), 0);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_q", int'(quotient), 4);
        chk("hold_r", int'(remainder), 1);

        issue(15, 1, 15, 0, 0); drain();
        issue(5, 9, 0, 5, 0);   drain();
        issue(0, 7, 0, 0, 0);   drain();
        issue(15, 15, 1, 0, 0); drain();

        issue(7, 0, 15, 7, 1);
        chk("dbz_busy", int'(busy), 0);
        drain();
        issue(8, 2, 4, 0, 0); drain();

        issue(14, 3, 4, 2, 0);
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dividend = W'(hv_a[i]);
            divisor  = W'(hv_b[i]);
            push(hv_a[i], hv_b[i], hv_q[i], hv_r[i], 1'b0);
            @(negedge clk);
            if (i == 3) start = 1'b0;
            repeat (W) @(negedge clk);
        end
        drain();

        issue(12, 5, 2, 2, 0);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q", int'(quotient), 0);
        chk("abort_r", int'(remainder), 0);
        chk("abort_dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(12, 5, 2, 2, 0);
        drain();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) issue(a, b, 15, a, 1);
                else issue(a, b, a / b, a % b, 0);
                drain();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
